// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/accumulator: default sizes,
// accumulator width rule and the two-state controller encoding.
package adder_pkg;

  localparam int WIDTH_DEF = 7;
  localparam int NOPS_DEF  = 10;

  // Accumulator is wide enough that NOPS full-scale operands plus a carry-in
  // can never wrap.
  function automatic int acc_width(input int width, input int nops);
    return width + $clog2(nops) + 1;
  endfunction

  localparam int ACC_W = WIDTH_DEF + $clog2(NOPS_DEF) + 1;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_acc.sv
// Serial adder/accumulator: sums NOPS unsigned operand beats plus a carry-in
// taken on the first beat, then presents the WIDTH-bit sum and carry-out
// through a valid/ready result port.
// Optional feature: define ADDER_ACC_SAT_EN to clamp the sum to all-ones on
// overflow (co behaves the same in both builds).
module serial_adder_acc
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NOPS  = NOPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int AW    = acc_width(WIDTH, NOPS);
  localparam int CNT_W = 4;

`ifdef ADDER_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      acc_sum;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   s_q;
  logic               co_q;
  logic               beat;
  logic               last_beat;
  logic               xfer;
  logic               ovf;

  // Clamp to all-ones on overflow when saturation is built in, else wrap.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] lo,
                                               input logic             over);
    return (SAT_EN && over) ? {WIDTH{1'b1}} : lo;
  endfunction

  // Handshake decode and the running sum for the beat being offered.
  always_comb begin
    beat      = in_valid && (state_q == ACCUM);
    last_beat = beat && (cnt_q == CNT_W'(NOPS - 1));
    xfer      = out_ready && (state_q == RESULT);
    if (cnt_q == '0) begin
      acc_sum = AW'(in_data) + AW'(in_ci);
    end else begin
      acc_sum = acc_q + AW'(in_data);
    end
    ovf = |acc_sum[AW-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_d = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Accumulator, beat counter and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
    end else if (xfer) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (beat) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_beat) begin
        s_q  <= sat_sum(acc_sum[WIDTH-1:0], ovf);
        co_q <= ovf;
      end
    end
  end

  assign s  = s_q;
  assign co = co_q;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Self-checking bench for serial_adder_acc (WIDTH=7, NOPS=10): fixed vectors,
// randomized sums with input gaps, backpressure and reset scenarios, checked
// against an arithmetic reference model.
module tb_serial_adder_acc;

  localparam int W    = 7;
  localparam int NOPS = 10;

`ifdef ADDER_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder_acc #(.WIDTH(W), .NOPS(NOPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: total of operands plus carry-in, then wrap or clamp.
  function automatic int model_total(input int ops[NOPS], input bit ci);
    int t;
    t = ci;
    foreach (ops[i]) t += ops[i];
    return t;
  endfunction

  function automatic int model_s(input int t);
    if (t >= (1 << W)) return SAT ? ((1 << W) - 1) : (t % (1 << W));
    return t;
  endfunction

  function automatic bit model_co(input int t);
    return t >= (1 << W);
  endfunction

  // Drives one full sum; returns at the negedge after the last beat.
  // Carry-in is randomised on non-first beats, where it must be ignored.
  task automatic drive_sum(input int ops[NOPS], input bit ci, input int gap_pct);
    for (int i = 0; i < NOPS; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_ci    = 1'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'(ops[i]);
      in_ci    = (i == 0) ? ci : 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ci = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++;
    if (s !== '0) begin tests_failed++; $display("FAIL reset_s got=%0d exp=0", s); end
    tests_run++;
    if (co !== 1'b0) begin tests_failed++; $display("FAIL reset_co got=%b exp=0", co); end
  endtask

  task automatic test_vectors;
    int vec [5][NOPS];
    bit vci [5];
    int es  [5];
    bit eco [5];
    vec[0] = '{1,1,1,1,1,1,1,1,1,1};          vci[0] = 0; es[0] = 10;  eco[0] = 0;
    vec[1] = '{1,2,3,4,5,6,7,8,9,10};         vci[1] = 0; es[1] = 55;  eco[1] = 0;
    vec[2] = '{12,12,12,12,12,12,12,12,12,12}; vci[2] = 1; es[2] = 121; eco[2] = 0;
    vec[3] = '{15,15,15,15,15,15,15,15,1,1};  vci[3] = 1; es[3] = 123; eco[3] = 0;
    vec[4] = '{10,15,15,15,7,12,13,15,15,10}; vci[4] = 1; es[4] = SAT ? 127 : 0; eco[4] = 1;
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      drive_sum(vec[v], vci[v], 0);
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_latency out_valid got=%b exp=1", v, out_valid); end
      tests_run++;
      if (s !== W'(es[v])) begin tests_failed++; $display("FAIL vec%0d_s got=%0d exp=%0d", v, s, es[v]); end
      tests_run++;
      if (co !== eco[v]) begin tests_failed++; $display("FAIL vec%0d_co got=%b exp=%b", v, co, eco[v]); end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL vec%0d_return out_valid=%b in_ready=%b exp 0/1", v, out_valid, in_ready);
      end
      tests_run++;
      if (s !== W'(es[v])) begin tests_failed++; $display("FAIL vec%0d_retain got=%0d exp=%0d", v, s, es[v]); end
    end
  endtask

  task automatic test_random;
    int ops[NOPS];
    bit ci;
    int t;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      foreach (ops[i]) ops[i] = (n % 2 == 0) ? int'($urandom_range(15)) : int'($urandom_range(127));
      ci = 1'($urandom);
      t = model_total(ops, ci);
      drive_sum(ops, ci, 20);
      tests_run++;
      if (out_valid !== 1'b1 || s !== W'(model_s(t)) || co !== model_co(t)) begin
        tests_failed++;
        $display("FAIL random%0d out_valid=%b s=%0d co=%b exp 1/%0d/%b (T=%0d)", n, out_valid, s, co, model_s(t), model_co(t), t);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gaps;
    int ops[NOPS];
    ops = '{1,2,3,4,5,6,7,8,9,10};
    out_ready = 1'b1;
    drive_sum(ops, 1'b0, 30);
    tests_run++;
    if (out_valid !== 1'b1 || s !== W'(55) || co !== 1'b0) begin
      tests_failed++; $display("FAIL gaps out_valid=%b s=%0d co=%b exp 1/55/0", out_valid, s, co);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int ops[NOPS];
    bit ci;
    int t;
    foreach (ops[i]) ops[i] = int'($urandom_range(20));
    ci = 1'b1;
    t = model_total(ops, ci);
    out_ready = 1'b0;
    drive_sum(ops, ci, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = W'($urandom);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== W'(model_s(t)) || co !== model_co(t)) begin
        tests_failed++;
        $display("FAIL backpressure%0d out_valid=%b in_ready=%b s=%0d co=%b exp 1/0/%0d/%b", k, out_valid, in_ready, s, co, model_s(t), model_co(t));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    ops = '{1,2,3,4,5,6,7,8,9,10};
    drive_sum(ops, 1'b0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || s !== W'(55) || co !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_next out_valid=%b s=%0d co=%b exp 1/55/0", out_valid, s, co);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ops[NOPS];
    out_ready = 1'b1;
    // Partial sum of 4 beats, then reset with a beat offered at the same edge.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = W'($urandom_range(127, 1)); in_ci = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = W'(99);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== '0 || co !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_accum out_valid=%b in_ready=%b s=%0d co=%b exp 0/1/0/0", out_valid, in_ready, s, co);
    end
    ops = '{0,0,0,0,0,0,0,0,0,0};
    drive_sum(ops, 1'b0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || s !== '0 || co !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_zero out_valid=%b s=%0d co=%b exp 1/0/0", out_valid, s, co);
    end
    @(negedge clk);
    // Reset while an unaccepted result is pending, with out_ready raised too.
    foreach (ops[i]) ops[i] = int'($urandom_range(127, 20));
    out_ready = 1'b0;
    drive_sum(ops, 1'b1, 0);
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || s !== '0 || co !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_result out_valid=%b s=%0d co=%b exp 0/0/0", out_valid, s, co);
    end
    ops = '{1,2,3,4,5,6,7,8,9,10};
    drive_sum(ops, 1'b0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || s !== W'(55) || co !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_after out_valid=%b s=%0d co=%b exp 1/55/0", out_valid, s, co);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_adder_acc.md
SERIAL_ADDER_ACC -- requirements
Module: serial_adder_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 7, giving the operand and sum width in bits.
REQ-002 SHALL have parameter NOPS, default 10, giving the number of operands per sum (range 2..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, indicating the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1, indicating the block accepts an operand beat.
REQ-007 SHALL have port in_data, input, WIDTH, the operand (unsigned).
REQ-008 SHALL have port in_ci, input, 1, the carry-in; it is sampled only on the first beat of a sum.
REQ-009 SHALL have port out_valid, output, 1, indicating the result is valid.
REQ-010 SHALL have port out_ready, input, 1, indicating the consumer accepts the result.
REQ-011 SHALL have port s, output, WIDTH, the sum.
REQ-012 SHALL have port co, output, 1, the carry-out/overflow flag.

Function
REQ-013 A beat SHALL transfer when in_valid && in_ready on a rising edge; a result SHALL transfer when out_valid && out_ready.
REQ-014 The FSM SHALL have exactly two states.
- ACCUM: in_ready=1, out_valid=0.
- RESULT: in_ready=0, out_valid=1.
REQ-015 On the first accepted beat (beat count 0), the accumulator SHALL load in_data + in_ci.
REQ-016 On each later accepted beat, the accumulator SHALL add in_data.
REQ-017 The beat counter SHALL increment on each accepted beat.
REQ-018 When beat NOPS-1 is accepted, the FSM SHALL go to RESULT on the next cycle, with s/co registered. Latency from the last beat to out_valid is 1 cycle.
REQ-019 For total T = sum of operands + ci: co = (T >= 2^WIDTH) and s = T mod 2^WIDTH, unless saturation is enabled (REQ-029).
REQ-020 The internal accumulator width SHALL be ACC_W bits, so that T never wraps internally.
REQ-021 In RESULT, s/co/out_valid SHALL be held stable until out_ready=1.
REQ-022 On the cycle a result transfers, the FSM SHALL clear the accumulator and counter and return to ACCUM. in_ready rises on the following cycle; there is no same-cycle bypass.
REQ-023 in_valid asserted in RESULT SHALL be ignored; no beat is consumed.
REQ-024 A gap in in_valid during ACCUM SHALL hold the accumulator and counter unchanged.
REQ-025 While in ACCUM, s and co SHALL retain the last result; 0 after reset.

Reset
REQ-026 reset=1 at a rising edge SHALL force:
- state=ACCUM
- accumulator=0, counter=0
- s=0, co=0, out_valid=0, in_ready=1 (in the cycle after reset)
REQ-027 Reset during ACCUM (partial sum) or RESULT (unaccepted result) SHALL discard that data.
REQ-028 reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-029 Saturation SHALL be controlled by macro ADDER_ACC_SAT_EN.
- Defined: when co=1, s SHALL be all-ones (2^WIDTH-1).
- Undefined: s wraps per REQ-019.
- co is identical in both builds.

Structure
REQ-030 Shared package adder_pkg SHALL hold:
- WIDTH and NOPS defaults
- ACC_W = WIDTH + $clog2(NOPS) + 1
- the state enum {ACCUM, RESULT}
REQ-031 The block SHALL be a single module with no sub-module; the FSM, counter and adder are inline.

Verification (WIDTH=7, NOPS=10, back-to-back beats, out_ready=1 unless stated)
REQ-032 All operands 1, ci=0 -> s=10, co=0, out_valid one cycle after the 10th beat.
REQ-033 Operands 1..10, ci=0 -> s=55, co=0. All operands 12, ci=1 -> s=121, co=0.
REQ-034 Operands 15,15,15,15,15,15,15,15,1,1, ci=1 -> s=123, co=0. Operands 10,15,15,15,7,12,13,15,15,10, ci=1 (T=128):
- without ADDER_ACC_SAT_EN -> s=0, co=1
- with ADDER_ACC_SAT_EN -> s=127, co=1
REQ-035 Backpressure: out_ready=0 for 5 cycles with in_valid held high -> s/co stable, in_ready=0, no beat consumed; on out_ready=1 -> one transfer, then the next sum starts cleanly.
REQ-036 Reset after 4 beats, then operands all 0, ci=0 -> s=0, co=0; the partial sum is discarded and no stale out_valid is seen.
REQ-037 Random in_valid gaps (~30%) with operands 1..10 -> s=55, identical to the gap-free result.
